// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI4 burst definitions for the address generator, VIP responder and monitor.
// Pure types and constants; no latency or backpressure.
package axi_defs;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int STRB_WIDTH     = AXI_DATA_WIDTH / 8;
  localparam int AXI_4KB        = 4096;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [2:0] {
    BYTES_1   = 3'd0,
    BYTES_2   = 3'd1,
    BYTES_4   = 3'd2,
    BYTES_8   = 3'd3,
    BYTES_16  = 3'd4,
    BYTES_32  = 3'd5,
    BYTES_64  = 3'd6,
    BYTES_128 = 3'd7
  } axi_size_e;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]  len;
    axi_size_e                 size;
    axi_burst_e                burst;
    logic [AXI_ID_WIDTH-1:0]   id;
  } axi_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } axi_agen_state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [31:0] len);
    return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_strb_calc.sv
// Beat address + size to active byte lanes, from the address lane up to the end of the size container.
// Combinational, zero latency; no backpressure.
module axi_strb_calc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [2:0]              i_size,
  output logic [DATA_WIDTH/8-1:0] o_strb
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] w_lo;
  logic [ADDR_WIDTH-1:0] w_hi;

  assign w_lo = i_addr & ADDR_WIDTH'(STRB_W - 1);
  assign w_hi = w_lo | ((A_ONE << i_size) - A_ONE);

  always_comb begin
    o_strb = '0;
    for (int i = 0; i < STRB_W; i++) begin
      o_strb[i] = (ADDR_WIDTH'(i) >= w_lo) && (ADDR_WIDTH'(i) <= w_hi);
    end
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI4 FIXED/INCR/WRAP beat sequencer with legality check; AXI_4KB_CHECK_EN adds the INCR 4KB-crossing check.
// Beat 0 one cycle after command accept; beats hold while beat_ready is low, cmd_ready low for the whole burst.
module axi_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ADDR_WIDTH-1:0]   beat_addr,
  output logic [DATA_WIDTH/8-1:0] beat_strb,
  output logic [LEN_WIDTH-1:0]    beat_idx,
  output logic                    beat_last,
  output logic [ID_WIDTH-1:0]     beat_id,
  output logic [1:0]              beat_resp
);

  import axi_defs::*;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  axi_agen_state_e       r_state;
  axi_agen_state_e       w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_wrap_lower;
  logic [ADDR_WIDTH-1:0] r_wrap_upper;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [2:0]            r_size;
  axi_burst_e            r_burst;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_illegal;

  logic                  w_cmd_ready;
  logic                  w_beat_valid;
  logic                  w_cmd_hs;
  logic                  w_beat_hs;
  logic                  w_last;
  axi_burst_e            w_burst;
  logic [ADDR_WIDTH-1:0] w_nb;
  logic [ADDR_WIDTH-1:0] w_total;
  logic [ADDR_WIDTH-1:0] w_wrap_lower;
  logic                  w_illegal;
  logic                  w_page_cross;
  logic [ADDR_WIDTH-1:0] w_cur_nb;
  logic [ADDR_WIDTH-1:0] w_wrap_step;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [STRB_W-1:0]     w_strb;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_ready  = 1'b0;
    w_beat_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = BURST;
      end
      BURST: begin
        w_beat_valid = 1'b1;
        if (beat_ready && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cmd_hs  = cmd_valid & w_cmd_ready;
  assign w_beat_hs = w_beat_valid & beat_ready;
  assign w_last    = (r_idx == r_len);

  // Command-side decode, evaluated on the incoming command.
  assign w_burst      = axi_burst_e'(cmd_burst);
  assign w_nb         = A_ONE << cmd_size;
  assign w_total      = (ADDR_WIDTH'(cmd_len) + A_ONE) << cmd_size;
  assign w_wrap_lower = cmd_addr & ~(w_total - A_ONE);

`ifdef AXI_4KB_CHECK_EN
  localparam int XW = ADDR_WIDTH + 16;
  localparam int PAGE_SHIFT = $clog2(AXI_4KB);
  logic [XW-1:0] w_pg_start;
  logic [XW-1:0] w_pg_end;
  assign w_pg_start   = XW'(cmd_addr & ~(w_nb - A_ONE));
  assign w_pg_end     = w_pg_start + ((XW'(cmd_len) + XW'(1)) << cmd_size) - XW'(1);
  assign w_page_cross = (w_burst == INCR) && ((XW'(cmd_addr) >> PAGE_SHIFT) != (w_pg_end >> PAGE_SHIFT));
`else
  assign w_page_cross = 1'b0;
`endif

  always_comb begin
    w_illegal = 1'b0;
    if (w_burst == RSVD) w_illegal = 1'b1;
    if ((w_burst == WRAP) && (!wrap_len_ok(32'(cmd_len)) || ((cmd_addr & (w_nb - A_ONE)) != '0)))
      w_illegal = 1'b1;
    if (cmd_size > SIZE_MAX) w_illegal = 1'b1;
    if (((w_burst == FIXED) || (w_burst == WRAP)) && (cmd_len > LEN_WIDTH'(15))) w_illegal = 1'b1;
    if (w_page_cross) w_illegal = 1'b1;
  end

  // Beat-side address advance from the registered command.
  assign w_cur_nb    = A_ONE << r_size;
  assign w_wrap_step = r_addr + w_cur_nb;

  always_comb begin
    w_addr_nxt = (r_addr & ~(w_cur_nb - A_ONE)) + w_cur_nb;
    case (r_burst)
      FIXED:   w_addr_nxt = r_addr;
      WRAP:    w_addr_nxt = (w_wrap_step == r_wrap_upper) ? r_wrap_lower : w_wrap_step;
      default: w_addr_nxt = (r_addr & ~(w_cur_nb - A_ONE)) + w_cur_nb;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_addr       <= '0;
      r_wrap_lower <= '0;
      r_wrap_upper <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= FIXED;
      r_id         <= '0;
      r_illegal    <= 1'b0;
    end else if (w_cmd_hs) begin
      r_addr       <= cmd_addr;
      r_wrap_lower <= w_wrap_lower;
      r_wrap_upper <= w_wrap_lower + w_total;
      r_idx        <= '0;
      r_len        <= cmd_len;
      r_size       <= cmd_size;
      r_burst      <= w_burst;
      r_id         <= cmd_id;
      r_illegal    <= w_illegal;
    end else if (w_beat_hs && !w_last) begin
      r_addr <= w_addr_nxt;
      r_idx  <= r_idx + LEN_WIDTH'(1);
    end
  end

  axi_strb_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strb_calc (
    .i_addr (r_addr),
    .i_size (r_size),
    .o_strb (w_strb)
  );

  assign cmd_ready  = w_cmd_ready;
  assign beat_valid = w_beat_valid;
  assign beat_addr  = r_addr;
  assign beat_idx   = r_idx;
  assign beat_id    = r_id;
  assign beat_last  = w_beat_valid && w_last;
  assign beat_strb  = (w_beat_valid && !r_illegal) ? w_strb : '0;
  assign beat_resp  = (w_beat_valid && r_illegal) ? 2'(SLVERR) : 2'(OKAY);

endmodule
